// File: rtl/release_sink_queue_pkg.sv
// Shared types and constants for the release sink queue.
//   release_payload_t : one release beat as carried by the network payload
//   client_id_t       : 2-bit client id, taken from the network header src
//   RTYPE_*           : release r_type encodings
//   has_data()        : true for the three data-carrying release types
package release_sink_queue_pkg;

  localparam int unsigned BEATS_DEFAULT = 8;

  typedef logic [1:0] client_id_t;

  localparam logic [2:0] RTYPE_INVALIDATE_DATA = 3'd0;
  localparam logic [2:0] RTYPE_DOWNGRADE_DATA  = 3'd1;
  localparam logic [2:0] RTYPE_COPY_DATA       = 3'd2;
  localparam logic [2:0] RTYPE_INVALIDATE_ACK  = 3'd3;
  localparam logic [2:0] RTYPE_DOWNGRADE_ACK   = 3'd4;
  localparam logic [2:0] RTYPE_COPY_ACK        = 3'd5;

  typedef struct packed {
    logic [2:0]  addr_beat;
    logic [25:0] addr_block;
    logic        client_xact_id;
    logic        voluntary;
    logic [2:0]  r_type;
    logic [63:0] data;
  } release_payload_t;

  function automatic logic has_data(input logic [2:0] r_type);
    return r_type <= RTYPE_COPY_DATA;
  endfunction

endpackage

// File: rtl/release_sink_queue_if.sv
// Handshake bundle between the release network output port (in side),
// the release consumer (out side) and the queue status outputs.
//   master : producer/consumer side (drives in_*, out_ready)
//   slave  : the queue itself
interface release_sink_queue_if #(
  parameter int unsigned DEPTH = 4
);
  import release_sink_queue_pkg::*;

  logic                     io_in_valid;
  logic                     io_in_ready;
  client_id_t               io_in_bits_header_src;
  client_id_t               io_in_bits_header_dst;
  logic [2:0]               io_in_bits_payload_addr_beat;
  logic [25:0]              io_in_bits_payload_addr_block;
  logic                     io_in_bits_payload_client_xact_id;
  logic                     io_in_bits_payload_voluntary;
  logic [2:0]               io_in_bits_payload_r_type;
  logic [63:0]              io_in_bits_payload_data;

  logic                     io_out_valid;
  logic                     io_out_ready;
  client_id_t               io_out_bits_client_id;
  logic [2:0]               io_out_bits_addr_beat;
  logic [25:0]              io_out_bits_addr_block;
  logic                     io_out_bits_client_xact_id;
  logic                     io_out_bits_voluntary;
  logic [2:0]               io_out_bits_r_type;
  logic [63:0]              io_out_bits_data;
  logic                     io_out_last;

  logic [$clog2(DEPTH):0]   io_count;
  logic                     io_err_beat;

  modport master (
    output io_in_valid, io_in_bits_header_src, io_in_bits_header_dst,
           io_in_bits_payload_addr_beat, io_in_bits_payload_addr_block,
           io_in_bits_payload_client_xact_id, io_in_bits_payload_voluntary,
           io_in_bits_payload_r_type, io_in_bits_payload_data, io_out_ready,
    input  io_in_ready, io_out_valid, io_out_bits_client_id, io_out_bits_addr_beat,
           io_out_bits_addr_block, io_out_bits_client_xact_id, io_out_bits_voluntary,
           io_out_bits_r_type, io_out_bits_data, io_out_last, io_count, io_err_beat
  );

  modport slave (
    input  io_in_valid, io_in_bits_header_src, io_in_bits_header_dst,
           io_in_bits_payload_addr_beat, io_in_bits_payload_addr_block,
           io_in_bits_payload_client_xact_id, io_in_bits_payload_voluntary,
           io_in_bits_payload_r_type, io_in_bits_payload_data, io_out_ready,
    output io_in_ready, io_out_valid, io_out_bits_client_id, io_out_bits_addr_beat,
           io_out_bits_addr_block, io_out_bits_client_xact_id, io_out_bits_voluntary,
           io_out_bits_r_type, io_out_bits_data, io_out_last, io_count, io_err_beat
  );

endinterface

// File: rtl/release_sink_queue_tracker.sv
// release_beat_tracker: follows the expected data beat index of incoming
// release messages and raises a sticky error on an out-of-order data beat.
//   clk, reset : clock, async active-low reset
//   enq        : a beat is being enqueued this cycle
//   r_type     : r_type of that beat (non-data beats are ignored)
//   addr_beat  : beat index of that beat
//   err_beat   : sticky out-of-order flag, cleared only by reset
module release_beat_tracker
  import release_sink_queue_pkg::*;
#(
  parameter int unsigned BEATS = BEATS_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enq,
  input  logic [2:0] r_type,
  input  logic [2:0] addr_beat,
  output logic       err_beat
);

  logic [2:0] exp_beat;
  logic [2:0] exp_beat_next;
  logic       data_beat;
  logic       mismatch;

  // On a match addr_beat equals exp_beat, so resyncing from addr_beat covers
  // both the in-order advance and the recovery after a mismatch.
  always_comb begin
    data_beat     = enq & has_data(r_type);
    mismatch      = data_beat & (addr_beat != exp_beat);
    exp_beat_next = exp_beat;
    if (data_beat) begin
      exp_beat_next = (addr_beat == 3'(BEATS - 1)) ? '0 : addr_beat + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      exp_beat <= '0;
      err_beat <= 1'b0;
    end else begin
      exp_beat <= exp_beat_next;
      if (mismatch) begin
        err_beat <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/release_sink_queue.sv
// release_sink_queue: buffers release beats from one release network output
// port and presents them, in order, to the release consumer.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   io    : release_sink_queue_if.slave
//           in_*   beat handshake from the network (header dst is dropped)
//           out_*  head entry handshake, client_id = stored header src
//           io_out_last  head beat ends its message
//           io_count     occupancy, io_err_beat sticky beat-order error
module release_sink_queue
  import release_sink_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned BEATS = BEATS_DEFAULT
) (
  input logic                clk,
  input logic                reset,
  release_sink_queue_if.slave io
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             in_ready_q;
  logic             out_valid;
  logic             enq;
  logic             deq;

  release_payload_t in_payload;
  release_payload_t head_payload;
  logic             in_last;

  release_payload_t pay_mem  [DEPTH];
  client_id_t       src_mem  [DEPTH];
  logic             last_mem [DEPTH];

  // The header destination only steers the network; nothing here uses it.
  logic [1:0] unused_dst;
  assign unused_dst = io.io_in_bits_header_dst;

  assign in_payload = '{
    addr_beat:      io.io_in_bits_payload_addr_beat,
    addr_block:     io.io_in_bits_payload_addr_block,
    client_xact_id: io.io_in_bits_payload_client_xact_id,
    voluntary:      io.io_in_bits_payload_voluntary,
    r_type:         io.io_in_bits_payload_r_type,
    data:           io.io_in_bits_payload_data
  };

  assign in_last   = !has_data(io.io_in_bits_payload_r_type)
                   | (io.io_in_bits_payload_addr_beat == 3'(BEATS - 1));
  assign out_valid = (count != '0);
  assign enq       = io.io_in_valid & in_ready_q;
  assign deq       = out_valid & io.io_out_ready;

  always_comb begin
    count_next = count;
    case ({enq, deq})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  // Ready is held in a flop tracking (count < DEPTH) one cycle ahead: it stays
  // low through reset, rises on the first edge after release, and a dequeue
  // from full only reopens the input on the following cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      in_ready_q <= 1'b0;
    end else begin
      if (enq) begin
        tail <= tail + PTR_W'(1);
      end
      if (deq) begin
        head <= head + PTR_W'(1);
      end
      count      <= count_next;
      in_ready_q <= (count_next < CNT_W'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      pay_mem[tail]  <= in_payload;
      src_mem[tail]  <= io.io_in_bits_header_src;
      last_mem[tail] <= in_last;
    end
  end

  assign head_payload = pay_mem[head];

  assign io.io_in_ready                = in_ready_q;
  assign io.io_out_valid               = out_valid;
  assign io.io_out_bits_client_id      = src_mem[head];
  assign io.io_out_bits_addr_beat      = head_payload.addr_beat;
  assign io.io_out_bits_addr_block     = head_payload.addr_block;
  assign io.io_out_bits_client_xact_id = head_payload.client_xact_id;
  assign io.io_out_bits_voluntary      = head_payload.voluntary;
  assign io.io_out_bits_r_type         = head_payload.r_type;
  assign io.io_out_bits_data           = head_payload.data;
  assign io.io_out_last                = out_valid & last_mem[head];
  assign io.io_count                   = count;

  release_beat_tracker #(
    .BEATS (BEATS)
  ) u_tracker (
    .clk       (clk),
    .reset     (reset),
    .enq       (enq),
    .r_type    (io.io_in_bits_payload_r_type),
    .addr_beat (io.io_in_bits_payload_addr_beat),
    .err_beat  (io.io_err_beat)
  );

endmodule

// File: tb/tb_release_sink_queue.sv
module tb_release_sink_queue;
  import release_sink_queue_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   accepted;

  release_sink_queue_if #(.DEPTH(DEPTH)) io();

  release_sink_queue #(
    .DEPTH (DEPTH),
    .BEATS (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .io    (io)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected {valid, client_id, payload, last} of a head beat built from its tag.
  function automatic logic [101:0] beat_word(input logic [1:0] src, input logic [2:0] beat,
                                             input logic [2:0] rt, input logic [7:0] tag,
                                             input logic last);
    return {1'b1, src, beat, {18'h2A5, tag}, tag[0], tag[1], rt,
            {56'hC0FFEE_0000_0000, tag}, last};
  endfunction

  function automatic logic [101:0] head_word();
    return {io.io_out_valid, io.io_out_bits_client_id, io.io_out_bits_addr_beat,
            io.io_out_bits_addr_block, io.io_out_bits_client_xact_id,
            io.io_out_bits_voluntary, io.io_out_bits_r_type, io.io_out_bits_data,
            io.io_out_last};
  endfunction

  task automatic drive(input logic [1:0] src, input logic [2:0] beat,
                       input logic [2:0] rt, input logic [7:0] tag);
    io.io_in_valid                       = 1'b1;
    io.io_in_bits_header_src             = src;
    io.io_in_bits_header_dst             = ~src;
    io.io_in_bits_payload_addr_beat      = beat;
    io.io_in_bits_payload_addr_block     = {18'h2A5, tag};
    io.io_in_bits_payload_client_xact_id = tag[0];
    io.io_in_bits_payload_voluntary      = tag[1];
    io.io_in_bits_payload_r_type         = rt;
    io.io_in_bits_payload_data           = {56'hC0FFEE_0000_0000, tag};
  endtask

  task automatic idle();
    io.io_in_valid = 1'b0;
  endtask

  task automatic chk_head(input string tag, input logic [1:0] src, input logic [2:0] beat,
                          input logic [2:0] rt, input logic [7:0] t, input logic last);
    chk(tag, head_word(), beat_word(src, beat, rt, t, last));
  endtask

  initial begin
    logic [2:0] t4_beat [4];
    logic       t4_err  [4];
    t4_beat = '{3'd0, 3'd1, 3'd3, 3'd4};
    t4_err  = '{1'b0, 1'b0, 1'b1, 1'b1};

    reset           = 1'b0;
    io.io_out_ready = 1'b0;
    drive(2'd0, 3'd0, 3'd0, 8'h00);
    idle();
    step();
    step();
    chk("rst_in_ready", io.io_in_ready, 0);
    chk("rst_out_valid", io.io_out_valid, 0);
    chk("rst_count", io.io_count, 0);
    chk("rst_last", io.io_out_last, 0);
    chk("rst_err", io.io_err_beat, 0);
    reset = 1'b1;
    step();
    chk("post_rst_in_ready", io.io_in_ready, 1);
    chk("post_rst_count", io.io_count, 0);

    // Eight-beat data message streaming straight through.
    io.io_out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(2'd2, 3'(i), RTYPE_INVALIDATE_DATA, 8'(8'h10 + i));
      step();
      chk("t1_beat", head_word(), beat_word(2'd2, 3'(i), 3'd0, 8'(8'h10 + i), (i == 7)));
      chk("t1_count", io.io_count, 1);
    end
    idle();
    step();
    chk("t1_drained", io.io_count, 0);
    chk("t1_valid", io.io_out_valid, 0);
    chk("t1_err", io.io_err_beat, 0);

    // Fill with the consumer stalled, then a single-cycle dequeue from full.
    io.io_out_ready = 1'b0;
    accepted = 0;
    for (int c = 0; c < 6; c++) begin
      drive(2'd1, 3'd0, RTYPE_DOWNGRADE_ACK, 8'(8'h30 + accepted));
      if (io.io_in_ready) accepted++;
      step();
    end
    chk("t2_accepted", 32'(accepted), 4);
    chk("t2_full_ready", io.io_in_ready, 0);
    chk("t2_full_count", io.io_count, 4);
    io.io_out_ready = 1'b1;
    chk("t2_ready_in_pulse", io.io_in_ready, 0);
    chk_head("t2_head0", 2'd1, 3'd0, 3'd4, 8'h30, 1'b1);
    step();
    io.io_out_ready = 1'b0;
    idle();
    chk("t2_after_pulse_count", io.io_count, 3);
    chk("t2_after_pulse_ready", io.io_in_ready, 1);
    chk_head("t2_head1", 2'd1, 3'd0, 3'd4, 8'h31, 1'b1);
    io.io_out_ready = 1'b1;
    step();
    chk_head("t2_head2", 2'd1, 3'd0, 3'd4, 8'h32, 1'b1);
    step();
    chk_head("t2_head3", 2'd1, 3'd0, 3'd4, 8'h33, 1'b1);
    step();
    chk("t2_drained", io.io_count, 0);
    io.io_out_ready = 1'b0;

    // Ack beat: last regardless of addr_beat, tracker untouched.
    drive(2'd3, 3'd5, RTYPE_INVALIDATE_ACK, 8'h50);
    step();
    idle();
    chk_head("t3_ack", 2'd3, 3'd5, 3'd3, 8'h50, 1'b1);
    chk("t3_count", io.io_count, 1);
    chk("t3_err", io.io_err_beat, 0);
    io.io_out_ready = 1'b1;
    step();
    chk("t3_drained", io.io_count, 0);

    // Data beats 0,1,3,4: error latches on beat 3 and persists.
    for (int k = 0; k < 4; k++) begin
      drive(2'd1, t4_beat[k], RTYPE_DOWNGRADE_DATA, 8'(8'h60 + k));
      step();
      chk_head("t4_beat", 2'd1, t4_beat[k], 3'd1, 8'(8'h60 + k), 1'b0);
      chk("t4_err", io.io_err_beat, t4_err[k]);
    end
    idle();
    step();
    chk("t4_drained", io.io_count, 0);
    chk("t4_err_sticky", io.io_err_beat, 1);

    // Simultaneous enqueue and dequeue at count 2.
    io.io_out_ready = 1'b0;
    drive(2'd0, 3'd2, RTYPE_COPY_ACK, 8'h70);
    step();
    drive(2'd0, 3'd2, RTYPE_COPY_ACK, 8'h71);
    step();
    chk("t5_count2", io.io_count, 2);
    drive(2'd0, 3'd2, RTYPE_COPY_ACK, 8'h72);
    io.io_out_ready = 1'b1;
    chk_head("t5_head70", 2'd0, 3'd2, 3'd5, 8'h70, 1'b1);
    step();
    idle();
    io.io_out_ready = 1'b0;
    chk("t5_count_same", io.io_count, 2);
    chk_head("t5_head71", 2'd0, 3'd2, 3'd5, 8'h71, 1'b1);
    io.io_out_ready = 1'b1;
    step();
    chk_head("t5_head72", 2'd0, 3'd2, 3'd5, 8'h72, 1'b1);
    step();
    chk("t5_drained", io.io_count, 0);
    io.io_out_ready = 1'b0;

    // Reset mid-message with three beats buffered.
    drive(2'd2, 3'd2, RTYPE_COPY_DATA, 8'h80);
    step();
    drive(2'd2, 3'd0, RTYPE_DOWNGRADE_ACK, 8'h81);
    step();
    drive(2'd2, 3'd0, RTYPE_DOWNGRADE_ACK, 8'h82);
    step();
    idle();
    chk("t6_count3", io.io_count, 3);
    chk("t6_err_before", io.io_err_beat, 1);
    reset = 1'b0;
    #1;
    chk("t6_rst_valid", io.io_out_valid, 0);
    chk("t6_rst_count", io.io_count, 0);
    chk("t6_rst_ready", io.io_in_ready, 0);
    chk("t6_rst_last", io.io_out_last, 0);
    chk("t6_rst_err", io.io_err_beat, 0);
    step();
    step();
    reset = 1'b1;
    step();
    chk("t6_post_ready", io.io_in_ready, 1);
    drive(2'd1, 3'd0, RTYPE_INVALIDATE_DATA, 8'h90);
    step();
    idle();
    chk_head("t6_beat0", 2'd1, 3'd0, 3'd0, 8'h90, 1'b0);
    chk("t6_count1", io.io_count, 1);
    chk("t6_err_clear", io.io_err_beat, 0);
    io.io_out_ready = 1'b1;
    step();
    chk("t6_drained", io.io_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/release_sink_queue.md
RELEASE_SINK_QUEUE -- requirements
Module: release_sink_queue

Interface
REQ-001 Parameter DEPTH, default 4, meaning number of buffered release beats, power of two, >= 2.
REQ-002 Parameter BEATS, default 8, meaning data beats per cache block; beat index 0..BEATS-1 carried in 3-bit addr_beat.
REQ-003 clk  input  1  single clock for all state, rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 io_in_valid / io_in_ready  input / output  1 / 1  beat handshake from one routed output port of the release network.
REQ-006 io_in_bits_header_src, io_in_bits_header_dst  input  2 each  network header; src is kept, dst is discarded.
REQ-007 io_in_bits_payload_addr_beat 3, _addr_block 26, _client_xact_id 1, _voluntary 1, _r_type 3, _data 64  input  release payload.
REQ-008 io_out_valid / io_out_ready  output / input  1 / 1  beat handshake to the release consumer.
REQ-009 io_out_bits_client_id 2 plus the REQ-007 payload fields  output  head entry; client_id is the stored header_src.
REQ-010 io_out_last  output  1  head beat is the final beat of its message.
REQ-011 io_count  output  clog2(DEPTH)+1  current occupancy.
REQ-012 io_err_beat  output  1  sticky flag: out-of-order data beat seen.

Function
REQ-013 Enqueue fires on io_in_valid & io_in_ready; dequeue fires on io_out_valid & io_out_ready.
REQ-014 io_in_ready = (count < DEPTH); it is registered-state only, with no combinational path from io_out_ready.
REQ-015 io_out_valid = (count != 0); io_out_bits and io_out_last come from the head entry only; no bypass; minimum in-to-out latency is 1 cycle.
REQ-016 Storage is a circular buffer with head/tail pointers of clog2(DEPTH) bits, wrapping from DEPTH-1 to 0.
REQ-017 Count update: +1 on enqueue only, -1 on dequeue only, unchanged on simultaneous enqueue and dequeue.
REQ-018 Full (count == DEPTH): io_in_ready = 0, even when a dequeue occurs in the same cycle; a dequeue while full frees a slot from the next cycle.
REQ-019 Empty (count == 0): a dequeue cannot occur; an enqueue makes io_out_valid = 1 in the next cycle.
REQ-020 has_data = (r_type < 3), covering releaseInvalidateData, releaseDowngradeData and releaseCopyData.
REQ-021 Stored last bit = !has_data | (addr_beat == BEATS-1), computed at enqueue.
REQ-022 Beat tracker: a register exp_beat (3 bits) updates on each enqueued has_data beat; it wraps to 0 after BEATS-1 and otherwise increments; non-data beats leave it unchanged.
REQ-023 An enqueued has_data beat with addr_beat != exp_beat sets io_err_beat = 1.
REQ-024 On a REQ-023 mismatch, exp_beat becomes (addr_beat+1) mod BEATS, or 0 if addr_beat == BEATS-1, and the beat is still stored unchanged.
REQ-025 io_err_beat stays set until reset.
REQ-026 Payload fields pass through bit-exact; io_in_bits_header_dst has no effect on any output.

Reset
REQ-027 While reset is low: head = tail = 0, count = 0, exp_beat = 0, io_err_beat = 0.
REQ-028 While reset is low: io_out_valid = 0, io_out_last = 0, io_count = 0, io_in_ready = 0.
REQ-029 Reset asserted mid-message or mid-transfer discards all buffered beats immediately.
REQ-030 After deassertion, io_in_ready = 1 from the first clock edge.
REQ-031 Storage array contents need not be reset; io_out_bits is don't-care while io_out_valid = 0.

Structure
REQ-032 A shared package holds the release payload struct (addr_beat, addr_block, client_xact_id, voluntary, r_type, data).
REQ-033 The same package holds r_type constants and the has_data function.
REQ-034 The same package holds the BEATS default and the 2-bit client id type.
REQ-035 One sub-module, release_beat_tracker, contains exp_beat, the REQ-022 to REQ-024 logic and io_err_beat; the circular buffer is inline.

Verification
REQ-036 Bench: after reset, enqueue 8 beats with r_type=0, addr_beat 0..7, src=2, with io_out_ready=1 -> 8 beats out in order, client_id=2, io_out_last=1 only on beat 7, io_err_beat=0.
REQ-037 Bench: io_out_ready=0, offer 6 beats -> 4 accepted, io_in_ready=0 with io_count=4; pulse io_out_ready for one cycle -> io_in_ready still 0 that cycle and 1 the next, io_count=3.
REQ-038 Bench: one beat with r_type=3 (ack, no data) and addr_beat=5 -> io_out_last=1, exp_beat unchanged, io_err_beat=0.
REQ-039 Bench: data beats with addr_beat 0,1,3 -> io_err_beat=1 after the third enqueue; the next beat with addr_beat=4 causes no further error, and the flag stays set.
REQ-040 Bench: count=2 with enqueue and dequeue in the same cycle -> io_count remains 2 and data ordering is preserved.
REQ-041 Bench: reset low while count=3 and exp_beat=3 -> io_out_valid=0 and io_count=0 immediately; after release, a beat with addr_beat=0 is accepted with no error.
